// File: rtl/gpzda_pkg.sv
// Shared types and constants for the $GPZDA body parser.
package gpzda_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StExpectComma,
    StField,
    StCkHi,
    StCkLo
  } state_e;

  // XOR of the header characters "GPZDA"
  localparam logic [7:0] CHECKSUM_SEED = 8'h48;

  localparam logic [2:0] F_TIME   = 3'd1;
  localparam logic [2:0] F_DAY    = 3'd2;
  localparam logic [2:0] F_MONTH  = 3'd3;
  localparam logic [2:0] F_YEAR   = 3'd4;
  localparam logic [2:0] F_ZONE_H = 3'd5;
  localparam logic [2:0] F_ZONE_M = 3'd6;

  localparam logic [7:0] ASCII_COMMA  = 8'h2C;
  localparam logic [7:0] ASCII_STAR   = 8'h2A;
  localparam logic [7:0] ASCII_DOLLAR = 8'h24;
  localparam logic [7:0] ASCII_DOT    = 8'h2E;

  localparam int unsigned TIME_DIGITS  = 6;
  localparam int unsigned DAY_DIGITS   = 2;
  localparam int unsigned MONTH_DIGITS = 2;
  localparam int unsigned YEAR_DIGITS  = 4;

  // Time may carry trailing fractional seconds; date fields must be exact.
  function automatic logic field_len_ok(input logic [2:0] idx, input int unsigned len);
    logic ok;
    case (idx)
      F_TIME:  ok = (len >= TIME_DIGITS);
      F_DAY:   ok = (len == DAY_DIGITS);
      F_MONTH: ok = (len == MONTH_DIGITS);
      F_YEAR:  ok = (len == YEAR_DIGITS);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ascii_hex_nibble.sv
// Combinational ASCII classifier: decimal digit, uppercase hex digit, nibble value.
module ascii_hex_nibble (
  input  logic [7:0] data,
  output logic       is_digit,
  output logic       is_hex,
  output logic [3:0] nibble
);

  logic is_upper;

  always_comb begin
    is_digit = (data >= 8'h30) && (data <= 8'h39);
    is_upper = (data >= 8'h41) && (data <= 8'h46);
    is_hex   = is_digit | is_upper;
    nibble   = 4'h0;
    if (is_digit) begin
      nibble = data[3:0];
    end else if (is_upper) begin
      nibble = data[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/gpzda_field_parser.sv
// Parses the $GPZDA body after a header match; publishes BCD time/date on a good checksum.
module gpzda_field_parser
  import gpzda_pkg::*;
#(
  parameter int unsigned B         = 8,
  parameter int unsigned MAX_FIELD = 15
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [B-1:0] data,
  input  logic         header_match,
  output logic [7:0]   hour,
  output logic [7:0]   minute,
  output logic [7:0]   second,
  output logic [7:0]   day,
  output logic [7:0]   month,
  output logic [15:0]  year,
  output logic         valid,
  output logic         error
);

  localparam int unsigned CW = $clog2(MAX_FIELD + 1);

  state_e        state_q, state_d;
  logic [2:0]    field_q, field_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    acc_q, acc_d;
  logic [3:0]    ck_hi_q, ck_hi_d;
  logic [23:0]   time_q, time_d;
  logic [7:0]    day_sh_q, day_sh_d;
  logic [7:0]    month_sh_q, month_sh_d;
  logic [15:0]   year_sh_q, year_sh_d;
  logic [7:0]    hour_q, minute_q, second_q, day_q, month_q;
  logic [15:0]   year_q;
  logic          valid_q, error_q;
  logic          valid_d, abort;

  logic [7:0] ch;
  logic       is_digit, is_hex;
  logic [3:0] nibble;

  assign ch = data[7:0];

  ascii_hex_nibble u_cls (
    .data     (ch),
    .is_digit (is_digit),
    .is_hex   (is_hex),
    .nibble   (nibble)
  );

  always_comb begin
    state_d    = state_q;
    field_d    = field_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    ck_hi_d    = ck_hi_q;
    time_d     = time_q;
    day_sh_d   = day_sh_q;
    month_sh_d = month_sh_q;
    year_sh_d  = year_sh_q;
    valid_d    = 1'b0;
    abort      = 1'b0;

    if (load) begin
      if (header_match) begin
        state_d = StExpectComma;
        acc_d   = CHECKSUM_SEED;
      end else if (state_q != StIdle && ch == ASCII_DOLLAR) begin
        abort = 1'b1;
      end else begin
        unique case (state_q)
          StIdle: ;
          StExpectComma: begin
            if (ch == ASCII_COMMA) begin
              acc_d   = acc_q ^ ch;
              field_d = F_TIME;
              cnt_d   = '0;
              state_d = StField;
            end else begin
              abort = 1'b1;
            end
          end
          StField: begin
            if (ch == ASCII_STAR) begin
              if (field_q == F_ZONE_M) state_d = StCkHi;
              else abort = 1'b1;
            end else if (ch == ASCII_COMMA) begin
              acc_d = acc_q ^ ch;
              if (field_q == F_ZONE_M || !field_len_ok(field_q, 32'(cnt_q))) begin
                abort = 1'b1;
              end else begin
                field_d = field_q + 3'd1;
                cnt_d   = '0;
              end
            end else begin
              acc_d = acc_q ^ ch;
              if (32'(cnt_q) == MAX_FIELD) begin
                abort = 1'b1;
              end else begin
                cnt_d = cnt_q + CW'(1);
                // Shadows shift in digits; a complete field fully overwrites stale content.
                case (field_q)
                  F_TIME: begin
                    if (32'(cnt_q) < TIME_DIGITS) begin
                      if (!is_digit) abort = 1'b1;
                      else time_d = {time_q[19:0], nibble};
                    end
                  end
                  F_DAY: begin
                    if (!is_digit) abort = 1'b1;
                    else if (32'(cnt_q) < DAY_DIGITS) day_sh_d = {day_sh_q[3:0], nibble};
                  end
                  F_MONTH: begin
                    if (!is_digit) abort = 1'b1;
                    else if (32'(cnt_q) < MONTH_DIGITS) month_sh_d = {month_sh_q[3:0], nibble};
                  end
                  F_YEAR: begin
                    if (!is_digit) abort = 1'b1;
                    else if (32'(cnt_q) < YEAR_DIGITS) year_sh_d = {year_sh_q[11:0], nibble};
                  end
                  default: ;
                endcase
              end
            end
          end
          StCkHi: begin
            if (is_hex) begin
              ck_hi_d = nibble;
              state_d = StCkLo;
            end else begin
              abort = 1'b1;
            end
          end
          StCkLo: begin
            state_d = StIdle;
            if (is_hex && {ck_hi_q, nibble} == acc_q) valid_d = 1'b1;
            else abort = 1'b1;
          end
          default: state_d = StIdle;
        endcase
      end
    end

    if (abort) state_d = StIdle;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      field_q    <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      ck_hi_q    <= '0;
      time_q     <= '0;
      day_sh_q   <= '0;
      month_sh_q <= '0;
      year_sh_q  <= '0;
      hour_q     <= '0;
      minute_q   <= '0;
      second_q   <= '0;
      day_q      <= '0;
      month_q    <= '0;
      year_q     <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      field_q    <= field_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      ck_hi_q    <= ck_hi_d;
      time_q     <= time_d;
      day_sh_q   <= day_sh_d;
      month_sh_q <= month_sh_d;
      year_sh_q  <= year_sh_d;
      valid_q    <= valid_d;
      error_q    <= abort;
      if (valid_d) begin
        hour_q   <= time_q[23:16];
        minute_q <= time_q[15:8];
        second_q <= time_q[7:0];
        day_q    <= day_sh_q;
        month_q  <= month_sh_q;
        year_q   <= year_sh_q;
      end
    end
  end

  assign hour   = hour_q;
  assign minute = minute_q;
  assign second = second_q;
  assign day    = day_q;
  assign month  = month_q;
  assign year   = year_q;
  assign valid  = valid_q;
  assign error  = error_q;

endmodule
